// File: rtl/uart_loop_arbiter.sv
// ---------------------------------------------------------------------------
// uart_loop_arbiter
//
// Byte-level arbiter between a UART receiver and transmitter. Received bytes
// (optionally folded to uppercase) are buffered in a small FIFO and echoed.
// A periodic fixed message is interleaved with the echo stream.
// Each message is sent back to back and is never interrupted.
// RX bytes that arrive during a message wait in the FIFO.
//
// Ports:
//   i_sys_clk     system clock
//   i_rst_n       synchronous, active-low reset
//   i_recv_en     one-cycle strobe, i_recv_data valid
//   i_recv_data   received byte
//   o_tx_valid    o_tx_data valid (transfer when o_tx_valid & i_tx_ready)
//   o_tx_data     byte to transmit
//   i_tx_ready    transmitter accepts the byte
//   i_msg_en      enables the periodic message timer
//   i_clr_ovf     clears the sticky overflow flag
//   o_fifo_level  echo FIFO occupancy
//   o_overflow    sticky: a received byte was dropped because the FIFO was full
//   o_msg_active  high while a message is being sent
// ---------------------------------------------------------------------------
module uart_loop_arbiter #(
    parameter int                   CLK_FRE    = 50,
    parameter int                   SEND_FRE   = 1,
    parameter int                   FIFO_DEPTH = 16,
    parameter int                   MSG_LEN    = 13,
    parameter logic [MSG_LEN*8-1:0] MSG_DATA   = "Hello World\r\n",
    parameter int                   ECHO_MODE  = 0
) (
    input  logic                            i_sys_clk,
    input  logic                            i_rst_n,
    input  logic                            i_recv_en,
    input  logic [7:0]                      i_recv_data,
    output logic                            o_tx_valid,
    output logic [7:0]                      o_tx_data,
    input  logic                            i_tx_ready,
    input  logic                            i_msg_en,
    input  logic                            i_clr_ovf,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_level,
    output logic                            o_overflow,
    output logic                            o_msg_active
);

    localparam int PERIOD = CLK_FRE * 1_000_000 / SEND_FRE;
    localparam int TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = $clog2(FIFO_DEPTH + 1);
    localparam int IW     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [IW-1:0] IDX_LAST   = IW'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOP = 2'd1,
        ST_MSG  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Message ROM: byte 0 is the first character of the string.
    // -----------------------------------------------------------------------
    logic [7:0] msg_rom [MSG_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < MSG_LEN; gi++) begin : g_msg_rom
            assign msg_rom[gi] = MSG_DATA[(MSG_LEN-1-gi)*8 +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Echo conversion
    // -----------------------------------------------------------------------
    logic [7:0] recv_byte;

    generate
        if (ECHO_MODE != 0) begin : g_upper
            // Clearing bit 5 maps a..z onto A..Z; everything else passes.
            assign recv_byte = ((i_recv_data >= 8'h61) && (i_recv_data <= 8'h7A))
                             ? (i_recv_data & 8'hDF) : i_recv_data;
        end else begin : g_raw
            assign recv_byte = i_recv_data;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Echo FIFO. The head is read combinationally, so a pop can load the
    // TX register on the same edge.
    // -----------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_wr;
    logic          fifo_drop;
    logic          fifo_pop;
    logic [7:0]    fifo_head;

    // The full test uses the level before the edge. So a byte that arrives
    // at full is dropped even when a pop happens in the same cycle.
    assign fifo_full  = (level_reg == LEVEL_FULL);
    assign fifo_empty = (level_reg == '0);
    assign fifo_wr    = i_recv_en && !fifo_full;
    assign fifo_drop  = i_recv_en && fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr_reg];

    always_ff @(posedge i_sys_clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_reg] <= recv_byte;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // If a clear and a new drop happen together, the set wins.
    logic overflow_reg;

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            overflow_reg <= 1'b0;
        end else if (fifo_drop) begin
            overflow_reg <= 1'b1;
        end else if (i_clr_ovf) begin
            overflow_reg <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Message timer and pending flag. Ticks that occur while a message is
    // already pending are merged into it. A tick on the same edge as the
    // IDLE state consuming the pending flag starts a new pending request.
    // -----------------------------------------------------------------------
    logic [TW-1:0] timer_reg;
    logic          pending_reg;
    logic          pend_clr;

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            timer_reg   <= '0;
            pending_reg <= 1'b0;
        end else if (!i_msg_en) begin
            timer_reg   <= '0;
            pending_reg <= 1'b0;
        end else if (timer_reg == TIMER_LAST) begin
            timer_reg   <= '0;
            pending_reg <= 1'b1;
        end else begin
            timer_reg <= timer_reg + TW'(1);
            if (pend_clr) begin
                pending_reg <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Arbitration FSM
    // -----------------------------------------------------------------------
    state_t        state_reg;
    state_t        state_next;
    logic          tx_valid_reg;
    logic          tx_valid_next;
    logic [7:0]    tx_data_reg;
    logic [7:0]    tx_data_next;
    logic [IW-1:0] msg_idx_reg;
    logic [IW-1:0] msg_idx_next;
    logic [IW-1:0] msg_idx_inc;
    logic          tx_xfer;

    assign tx_xfer     = tx_valid_reg && i_tx_ready;
    assign msg_idx_inc = msg_idx_reg + IW'(1);

    // State register
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A pending message takes priority over the FIFO.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pending_reg) begin
                    state_next = ST_MSG;
                end else if (!fifo_empty) begin
                    state_next = ST_LOOP;
                end
            end
            ST_LOOP: begin
                if (tx_xfer) begin
                    state_next = ST_IDLE;
                end
            end
            ST_MSG: begin
                if (tx_xfer && (msg_idx_reg == IDX_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / datapath logic. The TX byte is registered. IDLE always drops
    // o_tx_valid for one cycle while it arbitrates.
    always_comb begin
        tx_valid_next = tx_valid_reg;
        tx_data_next  = tx_data_reg;
        msg_idx_next  = msg_idx_reg;
        fifo_pop      = 1'b0;
        pend_clr      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tx_valid_next = 1'b0;
                if (pending_reg) begin
                    msg_idx_next  = '0;
                    tx_data_next  = msg_rom[0];
                    tx_valid_next = 1'b1;
                    pend_clr      = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    tx_data_next  = fifo_head;
                    tx_valid_next = 1'b1;
                end
            end
            ST_LOOP: begin
                if (tx_xfer) begin
                    tx_valid_next = 1'b0;
                end
            end
            ST_MSG: begin
                if (tx_xfer) begin
                    if (msg_idx_reg == IDX_LAST) begin
                        tx_valid_next = 1'b0;
                    end else begin
                        msg_idx_next = msg_idx_inc;
                        tx_data_next = msg_rom[msg_idx_inc];
                    end
                end
            end
            default: tx_valid_next = 1'b0;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            msg_idx_reg  <= '0;
        end else begin
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
            msg_idx_reg  <= msg_idx_next;
        end
    end

    assign o_tx_valid   = tx_valid_reg;
    assign o_tx_data    = tx_data_reg;
    assign o_fifo_level = level_reg;
    assign o_overflow   = overflow_reg;
    assign o_msg_active = (state_reg == ST_MSG);

endmodule

// File: tb/tb_uart_loop_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_loop_arbiter
//
// Directed testbench for uart_loop_arbiter with PERIOD = 100 cycles and
// FIFO_DEPTH = 4. Two instances share the same stimulus. One uses raw echo
// and the other uses uppercase echo. Transfers are recorded on the falling
// edge, and each check uses hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_uart_loop_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       recv_en;
    logic [7:0] recv_data;
    logic       tx_ready;
    logic       msg_en;
    logic       clr_ovf;

    logic       va, vb;
    logic [7:0] da, db;
    logic [2:0] la, lb;
    logic       oa, ob;
    logic       ma, mb;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int         act_cnt = 0;

    logic [7:0] exp_msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                                 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A};

    uart_loop_arbiter #(
        .CLK_FRE   (1),
        .SEND_FRE  (10000),
        .FIFO_DEPTH(4),
        .ECHO_MODE (0)
    ) dut (
        .i_sys_clk   (clk),
        .i_rst_n     (rst_n),
        .i_recv_en   (recv_en),
        .i_recv_data (recv_data),
        .o_tx_valid  (va),
        .o_tx_data   (da),
        .i_tx_ready  (tx_ready),
        .i_msg_en    (msg_en),
        .i_clr_ovf   (clr_ovf),
        .o_fifo_level(la),
        .o_overflow  (oa),
        .o_msg_active(ma)
    );

    uart_loop_arbiter #(
        .CLK_FRE   (1),
        .SEND_FRE  (10000),
        .FIFO_DEPTH(4),
        .ECHO_MODE (1)
    ) dut_up (
        .i_sys_clk   (clk),
        .i_rst_n     (rst_n),
        .i_recv_en   (recv_en),
        .i_recv_data (recv_data),
        .o_tx_valid  (vb),
        .o_tx_data   (db),
        .i_tx_ready  (tx_ready),
        .i_msg_en    (msg_en),
        .i_clr_ovf   (clr_ovf),
        .o_fifo_level(lb),
        .o_overflow  (ob),
        .o_msg_active(mb)
    );

    // Inputs change only at posedge + 1, so on the falling edge they show
    // what the next rising edge will see.
    always @(negedge clk) begin
        if (rst_n && va && tx_ready) got_a.push_back(da);
        if (rst_n && vb && tx_ready) got_b.push_back(db);
        if (ma) act_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b);
        recv_en   = 1'b1;
        recv_data = b;
        tick();
        recv_en   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        recv_en   = 1'b0;
        recv_data = 8'h00;
        tx_ready  = 1'b0;
        msg_en    = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid", 32'(va), 32'd0);
        chk("rst_data", 32'(da), 32'h00);
        chk("rst_level", 32'(la), 32'd0);
        chk("rst_ovf", 32'(oa), 32'd0);
        chk("rst_active", 32'(ma), 32'd0);

        // Echo: one byte, latency of one arbitration cycle
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        tick();
        got_a.delete();
        got_b.delete();
        pulse(8'h41);
        chk("echo_level1", 32'(la), 32'd1);
        chk("echo_valid0", 32'(va), 32'd0);
        tick();
        chk("echo_valid1", 32'(va), 32'd1);
        chk("echo_data", 32'(da), 32'h41);
        chk("echo_level0", 32'(la), 32'd0);
        chk("echo_up_data", 32'(db), 32'h41);
        tick();
        chk("echo_valid_drop", 32'(va), 32'd0);
        repeat (2) tick();
        chk("echo_count", 32'(got_a.size()), 32'd1);
        chk("echo_byte", 32'(got_a[0]), 32'h41);

        // Backpressure and overflow. EE stays in the TX register.
        // 01..04 fill the FIFO, and 05 and 06 are dropped.
        tx_ready = 1'b0;
        got_a.delete();
        pulse(8'hEE);
        for (int i = 1; i <= 6; i++) pulse(8'(i));
        chk("bp_level_full", 32'(la), 32'd4);
        chk("bp_ovf", 32'(oa), 32'd1);
        chk("bp_hold_valid", 32'(va), 32'd1);
        chk("bp_hold_data", 32'(da), 32'hEE);
        // Release one transfer. The FSM returns to IDLE and the FIFO is still full.
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("bp_idle_valid", 32'(va), 32'd0);
        chk("bp_idle_level", 32'(la), 32'd4);
        // The pop and the RX byte occur together at full. The byte is
        // dropped, and the new drop overrides the clear.
        recv_en   = 1'b1;
        recv_data = 8'h07;
        clr_ovf   = 1'b1;
        tick();
        recv_en = 1'b0;
        clr_ovf = 1'b0;
        chk("full_pop_level", 32'(la), 32'd3);
        chk("full_pop_ovf", 32'(oa), 32'd1);
        chk("full_pop_data", 32'(da), 32'h01);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(oa), 32'd0);
        tx_ready = 1'b1;
        repeat (8) tick();
        chk("bp_count", 32'(got_a.size()), 32'd5);
        chk("bp_b0", 32'(got_a[0]), 32'hEE);
        chk("bp_b1", 32'(got_a[1]), 32'h01);
        chk("bp_b2", 32'(got_a[2]), 32'h02);
        chk("bp_b3", 32'(got_a[3]), 32'h03);
        chk("bp_b4", 32'(got_a[4]), 32'h04);
        chk("bp_level_end", 32'(la), 32'd0);

        // Periodic message and pre-emption
        rst_n = 1'b0;
        repeat (2) tick();
        got_a.delete();
        got_b.delete();
        act_cnt = 0;
        rst_n   = 1'b1;
        msg_en  = 1'b1;
        repeat (100) tick();                 // edge 100: tick sets pending
        chk("msg_pre_valid", 32'(va), 32'd0);
        tick();                              // edge 101: first byte
        chk("msg_first_valid", 32'(va), 32'd1);
        chk("msg_first_data", 32'(da), 32'h48);
        chk("msg_active", 32'(ma), 32'd1);
        pulse(8'h61);                        // edges 102..104: buffered
        pulse(8'h7A);
        pulse(8'h5B);
        chk("pre_level", 32'(la), 32'd3);
        chk("pre_active", 32'(ma), 32'd1);
        repeat (17) tick();                  // through edge 121
        chk("msg_count", 32'(got_a.size()), 32'd16);
        for (int i = 0; i < 13; i++) chk($sformatf("msg_b%0d", i), 32'(got_a[i]), 32'(exp_msg[i]));
        chk("pre_echo0", 32'(got_a[13]), 32'h61);
        chk("pre_echo1", 32'(got_a[14]), 32'h7A);
        chk("pre_echo2", 32'(got_a[15]), 32'h5B);
        chk("up_count", 32'(got_b.size()), 32'd16);
        chk("up_echo0", 32'(got_b[13]), 32'h41);
        chk("up_echo1", 32'(got_b[14]), 32'h5A);
        chk("up_echo2", 32'(got_b[15]), 32'h5B);
        chk("active_cycles", 32'(act_cnt), 32'd13);
        chk("msg_end_valid", 32'(va), 32'd0);
        chk("msg_end_level", 32'(la), 32'd0);

        // Second message: tick at edge 200, first byte after edge 201
        repeat (79) tick();
        chk("msg2_pre_valid", 32'(va), 32'd0);
        tick();
        chk("msg2_valid", 32'(va), 32'd1);
        chk("msg2_data", 32'(da), 32'h48);

        // Reset at msg_idx = 5
        pulse(8'h33);                        // edge 202
        repeat (4) tick();                   // edge 206
        chk("mid_data", 32'(da), 32'h20);
        chk("mid_level", 32'(la), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(va), 32'd0);
        chk("midrst_level", 32'(la), 32'd0);
        chk("midrst_active", 32'(ma), 32'd0);
        chk("midrst_data", 32'(da), 32'h00);
        rst_n = 1'b1;
        repeat (100) tick();
        chk("post_pre_valid", 32'(va), 32'd0);
        tick();
        chk("post_valid", 32'(va), 32'd1);
        chk("post_data", 32'(da), 32'h48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_loop_arbiter.md
Name: uart_loop_arbiter

Overview:
- Byte-level arbiter between the UART receiver and transmitter. It merges a FIFO-buffered echo stream with a periodic fixed message and drives one TX byte stream.
- Generalises the single-byte loopback top with these additions: parametrised buffering depth, parametrised message, optional uppercase echo, message pre-emption rules and overflow status.
- Sits between the uart_rx byte outputs and the uart_tx byte inputs.

Parameters:
- CLK_FRE, 50, system clock in MHz.
- SEND_FRE, 1, periodic message rate in Hz. PERIOD = CLK_FRE*1_000_000/SEND_FRE cycles.
- FIFO_DEPTH, 16, echo FIFO depth. Must be a power of 2 and at least 2.
- MSG_LEN, 13, message length in bytes.
- MSG_DATA, "Hello World\r\n", MSG_LEN*8 bits. Byte i = MSG_DATA[(MSG_LEN-1-i)*8 +: 8], so bytes go out in string order.
- ECHO_MODE, 0. 0 = raw echo; 1 = bytes 8'h61..8'h7A are converted to 8'h41..8'h5A (a-z to A-Z) and all other bytes pass unchanged.

Ports:
- i_sys_clk  in  1  system clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_recv_en  in  1  one-cycle pulse: i_recv_data is valid.
- i_recv_data  in  8  received byte.
- o_tx_valid  out  1  o_tx_data is valid.
- o_tx_data  out  8  byte to transmit.
- i_tx_ready  in  1  transmitter accepts the byte. A transfer occurs when o_tx_valid=1 and i_tx_ready=1 on the same clock edge.
- i_msg_en  in  1  enables the periodic message.
- i_clr_ovf  in  1  clears o_overflow.
- o_fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- o_overflow  out  1  sticky flag: a received byte was dropped.
- o_msg_active  out  1  high while the FSM is in MSG.

Behaviour:
- Reset values, applied when i_rst_n=0 at the clock edge:
  - o_tx_valid=0, o_tx_data=0, o_fifo_level=0, o_overflow=0, o_msg_active=0.
  - FIFO empty, timer=0, pending=0, msg_idx=0, state=IDLE.
  - Reset mid-message or mid-byte abandons the transfer immediately.
- FIFO write:
  - On i_recv_en, the byte (after ECHO_MODE conversion) is written if level<FIFO_DEPTH.
  - If level==FIFO_DEPTH, the byte is dropped and o_overflow is set. The full check uses the pre-edge level, so a write is dropped at full even if a pop occurs in the same cycle.
  - A write and a pop in the same cycle when not full leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO head: read combinationally. A pop loads o_tx_data from the head on the same edge.
- Overflow flag: if i_clr_ovf and a new drop occur in the same cycle, the set wins.
- Timer:
  - Enabled when i_msg_en=1. It counts 0..PERIOD-1 and wraps.
  - At PERIOD-1 it sets pending. If pending is already set, the tick is coalesced and not queued.
  - When i_msg_en=0, the timer is held at 0 and pending is cleared. An in-progress message still completes.
- FSM states and transitions:
  - IDLE: o_tx_valid=0.
    - If pending: go to MSG; msg_idx=0; o_tx_data=byte 0; o_tx_valid=1; pending cleared.
    - Else if FIFO not empty: go to LOOP; pop; o_tx_valid=1.
    - Pending has priority over the FIFO.
  - LOOP: hold o_tx_valid and o_tx_data stable until a transfer occurs, then go to IDLE with o_tx_valid=0.
  - MSG:
    - On a transfer with msg_idx<MSG_LEN-1: msg_idx+1; o_tx_data=next byte; o_tx_valid stays 1, so bytes go back-to-back.
    - On a transfer with msg_idx==MSG_LEN-1: go to IDLE with o_tx_valid=0.
    - The message is atomic. RX bytes are only buffered during MSG.
- Timing:
  - After every LOOP byte and after a message ends, o_tx_valid is low for exactly one cycle (the IDLE arbitration cycle).
  - Echo latency: i_recv_en at edge N (state IDLE, no pending) gives o_tx_valid=1 after edge N+1.
- A timer tick during LOOP or MSG only sets pending. It is serviced at the next IDLE.

Test Plan:
- Simulation parameters for all scenarios: CLK_FRE=1, SEND_FRE=10000 (PERIOD=100), FIFO_DEPTH=4.
- Echo: i_msg_en=0, i_tx_ready=1, i_recv_en pulse with 8'h41 -> o_tx_valid high two edges later with data 8'h41 for one cycle; level returns to 0.
- Message: i_msg_en=1, i_tx_ready=1 -> after 100 cycles, 13 back-to-back bytes "Hello World\r\n" (8'h48 first, 8'h0A last); o_msg_active high for exactly 13 cycles; the next message starts 100 cycles after the previous tick.
- Backpressure plus overflow: i_tx_ready=0, 6 RX pulses 8'h01..8'h06 -> level saturates at 4, o_overflow=1; releasing ready yields 01,02,03,04 only; pulsing i_clr_ovf clears o_overflow.
- Pre-emption: during a message, 3 RX bytes arrive -> all are buffered (level=3) and echoed only after byte 8'h0A.
- Uppercase: ECHO_MODE=1, RX bytes 8'h61, 8'h7A, 8'h5B -> TX bytes 8'h41, 8'h5A, 8'h5B.
- Reset mid-message: assert i_rst_n=0 at msg_idx=5 -> next edge o_tx_valid=0, level=0, state IDLE; the first message after release starts 100 cycles later from byte 0.
